// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared encodings for the multi-cycle control FSM
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [3:0] {
    C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR,
    C_LUI, C_AUIPC, C_SYSTEM, C_ILLEGAL
  } iclass_t;

  localparam logic [1:0] ASEL_RS1  = 2'd0;
  localparam logic [1:0] ASEL_PC   = 2'd1;
  localparam logic [1:0] ASEL_ZERO = 2'd2;

  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_SUB   = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_IMM   = 2'd1;
  localparam logic [1:0] PC_ALU   = 2'd2;

endpackage

// File: rtl/inst_class_dec.sv
// rtl/inst_class_dec.sv - opcode to instruction class mapping
module inst_class_dec
  import ctrl_pkg::*;
#(
  parameter bit SUPPORT_AUIPC_LUI = 1'b1
) (
  input  logic [6:0] opcode,
  output iclass_t    iclass,
  output logic       illegal
);

  always_comb begin
    iclass = C_ILLEGAL;
    case (opcode)
      OP_R:      iclass = C_R;
      OP_I:      iclass = C_I;
      OP_LOAD:   iclass = C_LOAD;
      OP_STORE:  iclass = C_STORE;
      OP_BRANCH: iclass = C_BRANCH;
      OP_JAL:    iclass = C_JAL;
      OP_JALR:   iclass = C_JALR;
      OP_LUI:    iclass = SUPPORT_AUIPC_LUI ? C_LUI : C_ILLEGAL;
      OP_AUIPC:  iclass = SUPPORT_AUIPC_LUI ? C_AUIPC : C_ILLEGAL;
      OP_SYSTEM: iclass = C_SYSTEM;
      default:   iclass = C_ILLEGAL;
    endcase
    illegal = (iclass == C_ILLEGAL);
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - fetch/decode/exec/mem/wb sequencer for the femtoRV32 datapath
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned CNT_W             = 32,
  parameter bit          SUPPORT_AUIPC_LUI = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  input  logic             branch_taken,
  output logic             mem_req,
  output logic             mem_is_instr,
  output logic             mem_we,
  output logic             ir_we,
  output logic             imm_we,
  output logic [1:0]       alu_a_sel,
  output logic             alu_b_sel,
  output logic [1:0]       alu_op,
  output logic             rf_we,
  output logic [1:0]       wb_sel,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             halted,
  output logic             illegal_inst,
  output logic [CNT_W-1:0] instret
);

  state_t           state;
  iclass_t          iclass;
  logic             illegal;
  logic             ill_q;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       sel_a;
  logic             sel_b;
  logic [1:0]       sel_op;

  inst_class_dec #(.SUPPORT_AUIPC_LUI(SUPPORT_AUIPC_LUI)) u_dec (
    .opcode  (opcode),
    .iclass  (iclass),
    .illegal (illegal)
  );

  // ALU selects chosen in EXEC and held unchanged through MEM and WB
  always_comb begin
    sel_a  = ASEL_RS1;
    sel_b  = 1'b0;
    sel_op = ALU_ADD;
    case (iclass)
      C_R:              sel_op = ALU_FUNCT;
      C_I:              begin sel_b = 1'b1; sel_op = ALU_FUNCT; end
      C_LOAD, C_STORE:  sel_b = 1'b1;
      C_BRANCH:         sel_op = ALU_SUB;
      C_JAL, C_AUIPC:   begin sel_a = ASEL_PC; sel_b = 1'b1; end
      C_JALR:           sel_b = 1'b1;
      C_LUI:            begin sel_a = ASEL_ZERO; sel_b = 1'b1; end
      default:          ;
    endcase
  end

  always_comb begin
    mem_req      = 1'b0;
    mem_is_instr = 1'b0;
    mem_we       = 1'b0;
    ir_we        = 1'b0;
    imm_we       = 1'b0;
    alu_a_sel    = ASEL_RS1;
    alu_b_sel    = 1'b0;
    alu_op       = ALU_ADD;
    rf_we        = 1'b0;
    wb_sel       = WB_ALU;
    pc_we        = 1'b0;
    pc_src       = PC_PLUS4;
    halted       = 1'b0;
    if (!rst) begin
      case (state)
        S_FETCH: begin
          mem_req      = 1'b1;
          mem_is_instr = 1'b1;
          ir_we        = mem_ready;
        end
        S_DECODE: imm_we = 1'b1;
        S_EXEC: begin
          alu_a_sel = sel_a;
          alu_b_sel = sel_b;
          alu_op    = sel_op;
          if (iclass == C_BRANCH) begin
            pc_we  = 1'b1;
            pc_src = branch_taken ? PC_IMM : PC_PLUS4;
          end
        end
        S_MEM: begin
          mem_req   = 1'b1;
          mem_we    = (iclass == C_STORE);
          alu_a_sel = sel_a;
          alu_b_sel = sel_b;
          alu_op    = sel_op;
          pc_we     = mem_ready && (iclass == C_STORE);
        end
        S_WB: begin
          rf_we     = 1'b1;
          pc_we     = 1'b1;
          alu_a_sel = sel_a;
          alu_b_sel = sel_b;
          alu_op    = sel_op;
          case (iclass)
            C_LOAD:  wb_sel = WB_MEM;
            C_JAL:   begin wb_sel = WB_PC4; pc_src = PC_IMM; end
            C_JALR:  begin wb_sel = WB_PC4; pc_src = PC_ALU; end
            default: ;
          endcase
        end
        S_HALT: halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign illegal_inst = ill_q & ~rst;
  assign instret      = rst ? '0 : cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
      cnt   <= '0;
      ill_q <= 1'b0;
    end else begin
      // pc_we marks the final cycle of every instruction
      if (pc_we) cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      case (state)
        S_FETCH:  if (mem_ready) state <= S_DECODE;
        S_DECODE: begin
          if (iclass == C_SYSTEM) begin
            state <= S_HALT;
          end else if (illegal) begin
            state <= S_HALT;
            ill_q <= 1'b1;
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          case (iclass)
            C_BRANCH:        state <= S_FETCH;
            C_LOAD, C_STORE: state <= S_MEM;
            default:         state <= S_WB;
          endcase
        end
        S_MEM:    if (mem_ready) state <= (iclass == C_LOAD) ? S_WB : S_FETCH;
        S_WB:     state <= S_FETCH;
        S_HALT:   state <= S_HALT;
        default:  state <= S_FETCH;
      endcase
    end
  end

endmodule
